// File: rtl/fir_mac_scheduler_pkg.sv
// Shared types and constants for the time-multiplexed FIR MAC scheduler.
`default_nettype none

package fir_mac_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_MAC   = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 32;
  localparam int BUF_AW    = 5;

  // Headroom of 5 bits covers the sum of up to 32 full-scale products.
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw + 5;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_scheduler_if.sv
// Sample strobe, coefficient ROM handshake and result bus of the FIR MAC scheduler.
`default_nettype none

interface fir_mac_scheduler_if #(
  parameter int DW    = 16,
  parameter int CW    = 10,
  parameter int OUT_W = 16
);
  logic                    ready;
  logic signed [DW-1:0]    x;
  logic [4:0]              coeff_index;
  logic [1:0]              band_sel;
  logic signed [CW-1:0]    coeff;
  logic signed [OUT_W-1:0] y;
  logic [1:0]              y_band;
  logic                    y_valid;
  logic                    busy;
  logic                    overrun;

  modport slave (
    input  ready, x, coeff,
    output coeff_index, band_sel, y, y_band, y_valid, busy, overrun
  );

  modport master (
    output ready, x, coeff,
    input  coeff_index, band_sel, y, y_band, y_valid, busy, overrun
  );
endinterface

`default_nettype wire

// File: rtl/fir_mac_scheduler_sample_buffer.sv
// Circular sample history: one synchronous write port, one asynchronous read port, no reset.
`default_nettype none

module fir_mac_scheduler_sample_buffer #(
  parameter int DW    = 16,
  parameter int DEPTH = 32,
  parameter int AW    = 5
) (
  input  wire logic                 clock,
  input  wire logic                 we,
  input  wire logic [AW-1:0]        waddr,
  input  wire logic signed [DW-1:0] wdata,
  input  wire logic [AW-1:0]        raddr,
  output logic signed [DW-1:0]      rdata
);

  logic signed [DW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fir_mac_scheduler.sv
// One shared MAC walking NTAPS taps of NBANDS FIR filters per sample strobe.
// Build option FIR_SAT_EN: saturate the scaled result instead of wrapping it.
`default_nettype none

module fir_mac_scheduler
  import fir_mac_scheduler_pkg::*;
#(
  parameter int NTAPS  = 31,
  parameter int NBANDS = 2,
  parameter int DW     = 16,
  parameter int CW     = 10,
  parameter int ACC_W  = acc_width(DW, CW),
  parameter int SHIFT  = 10,
  parameter int OUT_W  = 16
) (
  input  wire logic             clock,
  input  wire logic             reset,
  fir_mac_scheduler_if.slave    bus
);

  localparam logic [BUF_AW-1:0] LAST_TAP  = BUF_AW'(NTAPS - 1);
  localparam logic [BUF_AW-1:0] LAST_SLOT = BUF_AW'(BUF_DEPTH - 1);
  localparam logic [1:0]        LAST_BAND = 2'(NBANDS - 1);
`ifdef FIR_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

  state_t                  state_q, state_d;
  logic [BUF_AW-1:0]       wptr_q, wptr_d;
  logic [BUF_AW-1:0]       newest_q, newest_d;
  logic [BUF_AW-1:0]       tap_q, tap_d;
  logic [1:0]              band_q, band_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] y_q, y_d;
  logic [1:0]              y_band_q, y_band_d;
  logic                    y_valid_q, y_valid_d;
  logic                    overrun_q, overrun_d;

  logic                    buf_we;
  logic signed [DW-1:0]    buf_wdata;
  logic signed [DW-1:0]    sample;
  logic signed [DW+CW-1:0] prod;
  logic signed [ACC_W-1:0] acc_sum;

  fir_mac_scheduler_sample_buffer #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH),
    .AW    (BUF_AW)
  ) u_buf (
    .clock (clock),
    .we    (buf_we),
    .waddr (wptr_q),
    .wdata (buf_wdata),
    .raddr (newest_q - tap_q),
    .rdata (sample)
  );

  assign prod    = $signed({{DW{bus.coeff[CW-1]}}, bus.coeff})
                 * $signed({{CW{sample[DW-1]}}, sample});
  assign acc_sum = acc_q + {{(ACC_W - DW - CW){prod[DW+CW-1]}}, prod};

  always_comb begin
    state_d   = state_q;
    wptr_d    = wptr_q;
    newest_d  = newest_q;
    tap_d     = tap_q;
    band_d    = band_q;
    acc_d     = acc_q;
    y_d       = y_q;
    y_band_d  = y_band_q;
    y_valid_d = 1'b0;
    buf_we    = 1'b0;
    buf_wdata = '0;
    // A strobe is only ever accepted from IDLE; anything else is lost and flagged.
    overrun_d = overrun_q | (bus.ready && (state_q != ST_IDLE));

    case (state_q)
      ST_CLEAR: begin
        buf_we = 1'b1;
        wptr_d = wptr_q + 1'b1;
        if (wptr_q == LAST_SLOT) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (bus.ready) begin
          buf_we    = 1'b1;
          buf_wdata = bus.x;
          newest_d  = wptr_q;
          wptr_d    = wptr_q + 1'b1;
          tap_d     = '0;
          band_d    = '0;
          acc_d     = '0;
          state_d   = ST_MAC;
        end
      end
      ST_MAC: begin
        if (tap_q == LAST_TAP) begin
`ifdef FIR_SAT_EN
          if ((acc_sum >>> SHIFT) > SAT_MAX) begin
            y_d = {1'b0, {(OUT_W - 1){1'b1}}};
          end else if ((acc_sum >>> SHIFT) < SAT_MIN) begin
            y_d = {1'b1, {(OUT_W - 1){1'b0}}};
          end else begin
            y_d = OUT_W'(acc_sum >>> SHIFT);
          end
`else
          y_d = OUT_W'(acc_sum >>> SHIFT);
`endif
          y_band_d  = band_q;
          y_valid_d = 1'b1;
          acc_d     = '0;
          tap_d     = '0;
          band_d    = band_q + 1'b1;
          if (band_q == LAST_BAND) begin
            state_d = ST_IDLE;
          end
        end else begin
          acc_d = acc_sum;
          tap_d = tap_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_CLEAR;
      wptr_q    <= '0;
      newest_q  <= '0;
      tap_q     <= '0;
      band_q    <= '0;
      acc_q     <= '0;
      y_q       <= '0;
      y_band_q  <= '0;
      y_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wptr_q    <= wptr_d;
      newest_q  <= newest_d;
      tap_q     <= tap_d;
      band_q    <= band_d;
      acc_q     <= acc_d;
      y_q       <= y_d;
      y_band_q  <= y_band_d;
      y_valid_q <= y_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.coeff_index = (state_q == ST_MAC) ? tap_q  : '0;
  assign bus.band_sel    = (state_q == ST_MAC) ? band_q : '0;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.y           = y_q;
  assign bus.y_band      = y_band_q;
  assign bus.y_valid     = y_valid_q;
  assign bus.overrun     = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: table of sample/expected-result rows plus
// hand-written overrun and mid-computation reset sequences.
`default_nettype none

module tb_fir_mac_scheduler;

  typedef struct {
    bit rst_first;
    int mode;
    int x;
    int exp0;
    int exp1;
  } vec_t;

  typedef struct {
    int band;
    int y;
    int cyc;
  } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   rom_mode = 0;
  int   cyc = 0;
  int   pulse_cyc = 0;
  int   acc_cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  res_t resq[$];
  vec_t vecs[$];

  fir_mac_scheduler_if bus ();

  fir_mac_scheduler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Coefficient ROMs, combinational from the DUT's tap/band selection.
  always_comb begin
    bus.coeff = '0;
    case (rom_mode)
      0: if (bus.band_sel == 2'd0) bus.coeff = 10'(int'(bus.coeff_index) * 10);
      1: begin
        if (bus.band_sel == 2'd0)      bus.coeff = 10'sd100;
        else if (bus.band_sel == 2'd1) bus.coeff = -10'sd1;
      end
      2: if (bus.band_sel <= 2'd1) bus.coeff = 10'sd511;
      default: bus.coeff = '0;
    endcase
  end

  always @(negedge clock) begin
    if (bus.y_valid) begin
      res_t r;
      r.band = int'(bus.y_band);
      r.y    = int'(bus.y);
      r.cyc  = cyc;
      resq.push_back(r);
    end
  end

  function automatic int fmt(input longint v);
`ifdef FIR_SAT_EN
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
`else
    logic signed [15:0] t;
    t = v[15:0];
    return int'(t);
`endif
  endfunction

  task automatic check(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Called at a negedge; returns at the negedge after the ready pulse was sampled.
  task automatic pulse(input int v);
    @(negedge clock);
    bus.ready = 1'b1;
    bus.x     = 16'(v);
    pulse_cyc = cyc;
    @(negedge clock);
    bus.ready = 1'b0;
    bus.x     = '0;
  endtask

  // Called at a negedge; asserts reset there, then releases it and times the clear phase.
  task automatic do_reset;
    int  n;
    bit  noisy;
    reset     = 1'b1;
    bus.ready = 1'b0;
    #1;
    check("rst_async_coeff_index", bus.coeff_index, 0);
    @(negedge clock);
    check("rst_busy", bus.busy, 1);
    check("rst_y_valid", bus.y_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_y", bus.y, 0);
    check("rst_band_sel", bus.band_sel, 0);
    reset = 1'b0;
    resq.delete();
    n = 0;
    noisy = 1'b0;
    while (bus.busy && n < 100) begin
      if (bus.y_valid || bus.overrun) noisy = 1'b1;
      n++;
      @(negedge clock);
    end
    check("clear_busy_cycles", n, 32);
    check("clear_quiet", noisy, 0);
  endtask

  task automatic collect(input string tag, input int e0, input int e1);
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done"}, bus.busy, 0);
    @(negedge clock);
    check({tag, "_count"}, resq.size(), 2);
    if (resq.size() == 2) begin
      check({tag, "_y0"}, resq[0].y, e0);
      check({tag, "_band0"}, resq[0].band, 0);
      check({tag, "_lat0"}, resq[0].cyc - acc_cyc - 1, 31);
      check({tag, "_y1"}, resq[1].y, e1);
      check({tag, "_band1"}, resq[1].band, 1);
      check({tag, "_lat1"}, resq[1].cyc - acc_cyc - 1, 62);
    end
    resq.delete();
  endtask

  task automatic run_row(input vec_t v, input string tag);
    if (v.rst_first) do_reset();
    rom_mode = v.mode;
    pulse(v.x);
    acc_cyc = pulse_cyc;
    collect(tag, v.exp0, v.exp1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    vec_t v;
    bus.ready = 1'b0;
    bus.x     = '0;

    // Impulse: band0 tap k coefficient is 10k, so the n-th sample's result is 10n.
    for (int n = 0; n < 31; n++) begin
      v = '{rst_first: (n == 0), mode: 0, x: (n == 0) ? 1024 : 0, exp0: n * 10, exp1: 0};
      vecs.push_back(v);
    end
    // DC: partial sums ramp until the history is full, then hold at 3100 / -31.
    for (int n = 0; n < 32; n++) begin
      int k;
      k = (n + 1 > 31) ? 31 : n + 1;
      v = '{rst_first: (n == 0), mode: 1, x: 1024, exp0: 100 * k, exp1: -k};
      vecs.push_back(v);
    end
    // Full-scale: 32767 * 511 per tap; the final row is the full 31-tap sum 506896.
    for (int n = 0; n < 31; n++) begin
      int e;
`ifdef FIR_SAT_EN
      e = (n == 30) ? 32767 : fmt((longint'(32767) * 511 * (n + 1)) >>> 10);
`else
      e = (n == 30) ? -17392 : fmt((longint'(32767) * 511 * (n + 1)) >>> 10);
`endif
      v = '{rst_first: (n == 0), mode: 2, x: 32767, exp0: e, exp1: e};
      vecs.push_back(v);
    end

    @(negedge clock);
    do_reset();

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

    // Overrun: a strobe 5 cycles into MAC and one on the finishing edge are both dropped.
    do_reset();
    rom_mode = 1;
    pulse(1024);
    acc_cyc = pulse_cyc;
    check("ovr_before", bus.overrun, 0);
    repeat (3) @(negedge clock);
    pulse(5000);
    collect("ovr_a", 100, -1);
    check("ovr_sticky_a", bus.overrun, 1);
    pulse(1024);
    acc_cyc = pulse_cyc;
    repeat (60) @(negedge clock);
    pulse(7000);
    check("ovr_edge_busy", bus.busy, 0);
    collect("ovr_b", 200, -2);
    pulse(1024);
    acc_cyc = pulse_cyc;
    collect("ovr_c", 300, -3);
    check("ovr_sticky_c", bus.overrun, 1);

    // Reset at tap 12 after leaving nonzero history behind; no residue may survive.
    do_reset();
    rom_mode = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(1024);
      acc_cyc = pulse_cyc;
      collect($sformatf("pre%0d", i), 10 * i * (i + 1) / 2, 0);
    end
    pulse(1024);
    repeat (12) @(negedge clock);
    check("mid_tap", bus.coeff_index, 12);
    do_reset();
    repeat (40) @(negedge clock);
    check("mid_no_y_valid", resq.size(), 0);
    for (int i = 0; i < 5; i++) begin
      vec_t w;
      w = vecs[i];
      w.rst_first = 1'b0;
      run_row(w, $sformatf("post%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
